// File: rtl/iir_cascade.sv
// iir_cascade: pipelined cascade of first-order IIR sections with global stall, live coefficient writes and sticky saturation
module iir_cascade #(
    parameter int DW   = 11,
    parameter int NSEC = 2,
    parameter int CW   = 12,
    parameter int FRAC = 10,
    localparam int SW  = (NSEC > 1) ? $clog2(NSEC) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] x,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic signed [DW-1:0] z,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 coef_we,
    input  logic [SW-1:0]        coef_sec,
    input  logic [1:0]           coef_sel,
    input  logic signed [CW-1:0] coef_data,
    input  logic                 clr,
    output logic                 sat
);
    localparam int PW = DW + CW;
    localparam int AW = DW + CW + 2;
    localparam logic signed [AW-1:0] YMAX = AW'((1 << (DW - 1)) - 1);
    localparam logic signed [AW-1:0] YMIN = -AW'(1 << (DW - 1));
    localparam logic signed [CW-1:0] ONE  = CW'(1 << FRAC);

    // stage 0 is the input register, stage k+1 holds the output of section k
    logic signed [DW-1:0] d_q  [NSEC+1];
    logic signed [DW-1:0] d_d  [NSEC+1];
    logic        [NSEC:0] v_q, v_d;
    logic signed [DW-1:0] xp_q [NSEC];
    logic signed [DW-1:0] xp_d [NSEC];
    logic signed [DW-1:0] yp_q [NSEC];
    logic signed [DW-1:0] yp_d [NSEC];
    logic signed [CW-1:0] b0_q [NSEC];
    logic signed [CW-1:0] b0_d [NSEC];
    logic signed [CW-1:0] b1_q [NSEC];
    logic signed [CW-1:0] b1_d [NSEC];
    logic signed [CW-1:0] a1_q [NSEC];
    logic signed [CW-1:0] a1_d [NSEC];
    logic                 sat_q, sat_d;
    logic signed [PW-1:0] p0   [NSEC];
    logic signed [PW-1:0] p1   [NSEC];
    logic signed [PW-1:0] p2   [NSEC];
    logic signed [AW-1:0] acc  [NSEC];
    logic signed [AW-1:0] sh   [NSEC];
    logic signed [DW-1:0] y    [NSEC];
    logic      [NSEC-1:0] ovf;
    logic                 adv;

    assign adv       = !v_q[NSEC] || out_ready;
    assign in_ready  = adv;
    assign z         = d_q[NSEC];
    assign out_valid = v_q[NSEC];
    assign sat       = sat_q;

    // per-section multiply-accumulate, floor scaling and saturation to the sample range
    always_comb begin
        for (int k = 0; k < NSEC; k++) begin
            p0[k]  = PW'(b0_q[k]) * PW'(d_q[k]);
            p1[k]  = PW'(b1_q[k]) * PW'(xp_q[k]);
            p2[k]  = PW'(a1_q[k]) * PW'(yp_q[k]);
            acc[k] = AW'(p0[k]) + AW'(p1[k]) - AW'(p2[k]);
            sh[k]  = acc[k] >>> FRAC;
            ovf[k] = (sh[k] > YMAX) || (sh[k] < YMIN);
            y[k]   = (sh[k] > YMAX) ? DW'(YMAX) : (sh[k] < YMIN) ? DW'(YMIN) : sh[k][DW-1:0];
        end
    end

    // pipeline advance, section history, sticky flag, clear and coefficient writes
    always_comb begin
        d_d   = d_q;
        v_d   = v_q;
        xp_d  = xp_q;
        yp_d  = yp_q;
        sat_d = sat_q;
        b0_d  = b0_q;
        b1_d  = b1_q;
        a1_d  = a1_q;
        if (adv) begin
            d_d[0] = x;
            v_d[0] = in_valid;
            for (int k = 0; k < NSEC; k++) begin
                d_d[k+1] = y[k];
                v_d[k+1] = v_q[k];
                if (v_q[k]) begin
                    xp_d[k] = d_q[k];
                    yp_d[k] = y[k];
                    sat_d   = sat_d | ovf[k];
                end
            end
        end
        if (clr) begin
            v_d   = '0;
            xp_d  = '{default: '0};
            yp_d  = '{default: '0};
            sat_d = 1'b0;
        end
        for (int k = 0; k < NSEC; k++) begin
            if (coef_we && coef_sec == SW'(k)) begin
                b0_d[k] = (coef_sel == 2'd0) ? coef_data : b0_q[k];
                b1_d[k] = (coef_sel == 2'd1) ? coef_data : b1_q[k];
                a1_d[k] = (coef_sel == 2'd2) ? coef_data : a1_q[k];
            end
        end
    end

    // state registers; coefficients reset to pass-through
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_q   <= '{default: '0};
            v_q   <= '0;
            xp_q  <= '{default: '0};
            yp_q  <= '{default: '0};
            sat_q <= 1'b0;
            b0_q  <= '{default: ONE};
            b1_q  <= '{default: '0};
            a1_q  <= '{default: '0};
        end else begin
            d_q   <= d_d;
            v_q   <= v_d;
            xp_q  <= xp_d;
            yp_q  <= yp_d;
            sat_q <= sat_d;
            b0_q  <= b0_d;
            b1_q  <= b1_d;
            a1_q  <= a1_d;
        end
    end
endmodule

// File: tb/tb_iir_cascade.sv
// tb_iir_cascade: directed checks of pass-through, recursion, clear, stall, saturation and async reset
module tb_iir_cascade;
    logic               clk;
    logic               rst;
    logic signed [10:0] x;
    logic               in_valid;
    logic               in_ready;
    logic signed [10:0] z;
    logic               out_valid;
    logic               out_ready;
    logic               coef_we;
    logic [0:0]         coef_sec;
    logic [1:0]         coef_sel;
    logic signed [11:0] coef_data;
    logic               clr;
    logic               sat;
    int                 errors = 0;
    int                 checks = 0;
    int                 rec [9] = '{200, 300, 350, 375, 387, 393, 396, 398, 399};

    iir_cascade dut (
        .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .in_ready(in_ready),
        .z(z), .out_valid(out_valid), .out_ready(out_ready),
        .coef_we(coef_we), .coef_sec(coef_sec), .coef_sel(coef_sel), .coef_data(coef_data),
        .clr(clr), .sat(sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input int sec, input int sel, input int data);
        coef_we   = 1'b1;
        coef_sec  = 1'(sec);
        coef_sel  = 2'(sel);
        coef_data = 12'(data);
        step();
        coef_we   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; coef_we = 1'b0; coef_sec = '0; coef_sel = '0; coef_data = '0;
        x = '0; in_valid = 1'b0; out_ready = 1'b1;
        #3 rst = 1'b0;
        step(); step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_z", z, 0);
        chk("rst_sat", sat, 0);
        rst = 1'b1;

        x = 11'sd100; in_valid = 1'b1; step();
        x = '0; step(); step();
        in_valid = 1'b0;
        chk("pt_z0", z, 100);
        chk("pt_valid0", out_valid, 1);
        step(); chk("pt_z1", z, 0); chk("pt_valid1", out_valid, 1);
        step(); chk("pt_z2", z, 0); chk("pt_sat", sat, 0);
        step(); chk("pt_drain", out_valid, 0);

        wr(0, 2, -512);
        x = 11'sd200; in_valid = 1'b1;
        step(); step(); step();
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("rec_z%0d", i), z, rec[i]);
            chk($sformatf("rec_valid%0d", i), out_valid, 1);
            step();
        end
        clr = 1'b1; step(); clr = 1'b0;
        chk("clr_valid", out_valid, 0);
        chk("clr_sat", sat, 0);
        step(); step();
        chk("clr_dropped", out_valid, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("clr_z%0d", i), z, rec[i]);
            if (i < 3) step();
        end

        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("bp_ready%0d", i), in_ready, 0);
            chk($sformatf("bp_z%0d", i), z, 375);
            chk($sformatf("bp_valid%0d", i), out_valid, 1);
        end
        out_ready = 1'b1;
        chk("bp_hold", z, 375);
        for (int i = 4; i < 9; i++) begin
            step();
            chk($sformatf("bp_z_after%0d", i), z, rec[i]);
        end
        in_valid = 1'b0;
        step(); step(); step(); step();

        wr(0, 2, 0);
        wr(0, 0, 2047);
        x = 11'sd1023; in_valid = 1'b1; step();
        in_valid = 1'b0; step(); step();
        chk("sat_z_hi", z, 1023);
        chk("sat_flag", sat, 1);
        x = -11'sd1024; in_valid = 1'b1; step();
        in_valid = 1'b0; step(); step();
        chk("sat_z_lo", z, -1024);
        chk("sat_flag2", sat, 1);
        step();
        chk("sat_drain", out_valid, 0);
        chk("sat_sticky", sat, 1);

        x = 11'sd50; in_valid = 1'b1;
        step(); step(); step();
        chk("ar_pre_z", z, 99);
        chk("ar_pre_valid", out_valid, 1);
        #2 rst = 1'b0;
        #1;
        chk("ar_z", z, 0);
        chk("ar_valid", out_valid, 0);
        chk("ar_sat", sat, 0);
        in_valid = 1'b0;
        step(); step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("ar_no_pulse%0d", i), out_valid, 0);
        end
        wr(0, 3, 0);
        x = 11'sd77; in_valid = 1'b1; step();
        in_valid = 1'b0; step(); step();
        chk("ar_coef_z", z, 77);
        chk("ar_coef_valid", out_valid, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/iir_cascade.md
IIR_CASCADE -- requirements
Module: iir_cascade

Interface
REQ-001 Parameter DW, default 11: signed sample width for x, z and all inter-section data.
REQ-002 Parameter NSEC, default 2: number of cascaded first-order sections (1..8).
REQ-003 Parameter CW, default 12: signed coefficient width.
REQ-004 Parameter FRAC, default 10: number of coefficient fractional bits (Q(CW-FRAC).FRAC).
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 x  in  DW  signed input sample.
REQ-008 in_valid  in  1  x is valid this cycle.
REQ-009 in_ready  out  1  block accepts x this cycle.
REQ-010 z  out  DW  signed filtered output.
REQ-011 out_valid  out  1  z is valid.
REQ-012 out_ready  in  1  downstream accepts z.
REQ-013 coef_we  in  1  coefficient write strobe.
REQ-014 coef_sec  in  max(1,$clog2(NSEC))  target section index.
REQ-015 coef_sel  in  2  0=b0, 1=b1, 2=a1, 3=ignored.
REQ-016 coef_data  in  CW  signed coefficient value.
REQ-017 clr  in  1  synchronous clear of filter state and pipeline.
REQ-018 sat  out  1  sticky saturation flag.

Function
REQ-019 The pipeline has NSEC+1 stages: an input register, then one registered stage per section.
- Each stage has its own valid bit.
REQ-020 Global advance: adv = !out_valid || out_ready.
- in_ready = adv.
- A sample is accepted when in_valid && in_ready.
REQ-021 When adv=1, every stage loads its predecessor's data and valid bit.
- When adv=0, all data, valid bits and section state hold.
REQ-022 Section k computes y = b0*xin + b1*xprev - a1*yprev.
- xprev and yprev update only when that section consumes a valid sample.
REQ-023 Arithmetic widths:
- Products are DW+CW bits.
- The sum is DW+CW+2 bits.
- The sum is arithmetic-shifted right by FRAC (floor).
- The result is saturated to [-2^(DW-1), 2^(DW-1)-1].
- The saturated value is stored both as the section output and as yprev.
REQ-024 If any section saturates on a valid sample, sat is set to 1.
- sat stays 1 until reset or clr.
REQ-025 Latency: a sample accepted in cycle n appears with out_valid=1 in cycle n+NSEC+1, provided no stall occurs.
- Throughput is one sample per cycle.
REQ-026 Coefficient write when coef_we=1:
- Updates the selected coefficient at the clock edge.
- The new value is used from the next cycle.
- coef_sec >= NSEC or coef_sel=3 has no effect.
- A write is allowed while data flows and does not stall the pipeline.
REQ-027 Coefficient reset values per section: b0 = 2^FRAC (1.0), b1 = 0, a1 = 0, i.e. pass-through.
REQ-028 clr=1, synchronous:
- Zeroes all valid bits, xprev, yprev and sat.
- Keeps coefficients.
- Overrides adv and any input accepted that cycle; that sample is dropped.
REQ-029 While out_valid=1 and out_ready=0, z shall remain stable.

Reset
REQ-030 When rst=0 (asynchronous):
- All stage data, xprev, yprev, valid bits, z and sat go to 0.
- Coefficients go to their REQ-027 values.
REQ-031 After reset: out_valid=0 and in_ready=1.
REQ-032 Reset mid-stream discards all in-flight samples; no out_valid pulse follows release of reset.
REQ-033 Reset release is synchronised to clk by the integrating design; the block itself adds no synchroniser.

Verification
Defaults apply: DW=11, NSEC=2, CW=12, FRAC=10; out_ready=1 unless stated.
REQ-034 Pass-through:
- Stimulus: after reset, inputs 100, 0, 0 on consecutive cycles.
- Response: z=100 three cycles after acceptance, then 0, 0; sat=0.
REQ-035 Recursion:
- Stimulus: write sec0 a1=-512 (-0.5); apply a constant 200 step.
- Response: z = 200, 300, 350, 375, 387, 393, 396, 398, 399 (floor rounding).
REQ-036 Saturation:
- Stimulus: write sec0 b0=2047; input 1023.
- Response: z=1023 and sat=1, which persists.
- Stimulus: input -1024.
- Response: z=-1024.
REQ-037 Backpressure:
- Stimulus: hold out_ready=0 for 5 cycles while data is in flight.
- Response during stall: in_ready=0; z and the output sequence are frozen.
- Response after release: identical output sequence to the unstalled run.
REQ-038 Clear:
- Stimulus: run REQ-035 for 4 outputs; assert clr for 1 cycle; restart the step.
- Response: the sequence restarts at 200; sat=0; coefficients retained.
REQ-039 Async reset:
- Stimulus: assert rst low between clock edges mid-stream.
- Response: outputs are 0 immediately; coefficients revert to pass-through; no out_valid pulse follows release.
